// File: rtl/dma_req_quiesce_if.sv
// rtl/dma_req_quiesce_if.sv - dmaIntf request/response channel with master and slave modports
interface dmaIntf #(
  parameter int REQ_W = 32,
  parameter int RSP_W = 32
) ();
  logic             valid;
  logic             ready;
  logic [REQ_W-1:0] req;
  logic             rsp_done;
  logic [RSP_W-1:0] rsp_data;

  modport m (output valid, req, input ready, rsp_done, rsp_data);
  modport s (input valid, req, output ready, rsp_done, rsp_data);
endinterface

// File: rtl/dma_req_quiesce.sv
// rtl/dma_req_quiesce.sv - outstanding-request tracker that drains a DMA channel before decoupling
// Optional drain watchdog enabled by DMA_QUIESCE_TIMEOUT_EN.
module dma_req_quiesce #(
  parameter int MAX_OUTSTANDING = 32,
  parameter int CNT_BITS        = $clog2(MAX_OUTSTANDING + 1),
  parameter int TIMEOUT_CYCLES  = 65536
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                drain_req,
  output logic                drain_ack,
  output logic                drain_err,
  output logic [CNT_BITS-1:0] outstanding,
  dmaIntf.s                   s_req,
  dmaIntf.m                   m_req
);

  typedef enum logic [1:0] {ACTIVE, DRAIN, QUIESCED} state_t;

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                ack_q;
  logic                has_room;
  logic                fwd_valid, fwd_ready;
  logic                fire, retire;

  assign has_room = (cnt_q < CNT_BITS'(MAX_OUTSTANDING));

  always_comb begin
    state_d   = state_q;
    fwd_valid = 1'b0;
    fwd_ready = 1'b0;
    case (state_q)
      ACTIVE: begin
        fwd_valid = s_req.valid && has_room;
        fwd_ready = m_req.ready && has_room;
        if (drain_req) state_d = DRAIN;
      end
      DRAIN: begin
        // Abort wins over completion so a dropped request never sees a stale ack.
        if (!drain_req)        state_d = ACTIVE;
        else if (cnt_q == '0)  state_d = QUIESCED;
      end
      QUIESCED: begin
        if (!drain_req) state_d = ACTIVE;
      end
      default: state_d = ACTIVE;
    endcase
  end

  assign m_req.valid    = fwd_valid;
  assign m_req.req      = s_req.req;
  assign s_req.ready    = fwd_ready;
  assign s_req.rsp_done = m_req.rsp_done;
  assign s_req.rsp_data = m_req.rsp_data;

  assign fire   = fwd_valid && m_req.ready;
  assign retire = m_req.rsp_done && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    case ({fire, retire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ACTIVE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= (state_d == QUIESCED);
    end
  end

  assign drain_ack   = ack_q;
  assign outstanding = cnt_q;

`ifdef DMA_QUIESCE_TIMEOUT_EN
  localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_BITS-1:0] wd_q;
  logic               err_q;

  // Held at zero outside DRAIN, so every entry into DRAIN starts a fresh count.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q != DRAIN)                         wd_q <= '0;
      else if (wd_q != WD_BITS'(TIMEOUT_CYCLES))    wd_q <= wd_q + 1'b1;

      if (state_d == ACTIVE && state_q != ACTIVE)   err_q <= 1'b0;
      else if (state_q == DRAIN && wd_q == WD_BITS'(TIMEOUT_CYCLES - 1))
                                                    err_q <= 1'b1;
    end
  end

  assign drain_err = err_q;
`else
  assign drain_err = 1'b0;
`endif

endmodule

// File: tb/tb_dma_req_quiesce.sv
// tb/tb_dma_req_quiesce.sv - directed self-checking bench for dma_req_quiesce with request scoreboard
module tb_dma_req_quiesce;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic       drain_req;
  logic       drain_ack, drain_err;
  logic [5:0] outstanding;
  logic       lim_drain_req;
  logic       lim_ack, lim_err;
  logic [2:0] lim_out;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] next_id  = 32'h100;
  logic [31:0] junk;
  int          acc;

  dmaIntf s_if ();
  dmaIntf m_if ();
  dmaIntf ls_if ();
  dmaIntf lm_if ();

  always #5 aclk = ~aclk;

  dma_req_quiesce #(.MAX_OUTSTANDING(32), .TIMEOUT_CYCLES(100)) u_dut (
    .aclk(aclk), .aresetn(aresetn), .drain_req(drain_req), .drain_ack(drain_ack),
    .drain_err(drain_err), .outstanding(outstanding), .s_req(s_if), .m_req(m_if)
  );

  dma_req_quiesce #(.MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(100)) u_lim (
    .aclk(aclk), .aresetn(aresetn), .drain_req(lim_drain_req), .drain_ack(lim_ack),
    .drain_err(lim_err), .outstanding(lim_out), .s_req(ls_if), .m_req(lm_if)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (aresetn) begin
      if (m_if.valid && m_if.ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL sb_unexpected_req observed=%0h expected=none", m_if.req);
        end else begin
          chk("sb_req", m_if.req, exp_q.pop_front());
        end
      end
      chk("rsp_done_mirror", s_if.rsp_done, m_if.rsp_done);
      chk("rsp_data_mirror", s_if.rsp_data, m_if.rsp_data);
      chk("fire_match", s_if.valid && s_if.ready, m_if.valid && m_if.ready);
    end
  end

  task automatic offer(input int n, output int accepted);
    int cyc;
    bit pend;
    accepted = 0;
    cyc      = 0;
    pend     = 0;
    while (accepted < n && cyc < 4 * n + 8) begin
      if (!pend) begin
        exp_q.push_back(next_id);
        s_if.req   = next_id;
        s_if.valid = 1'b1;
        pend       = 1;
      end
      @(negedge aclk);
      if (s_if.ready) begin
        accepted++;
        pend = 0;
        next_id++;
      end
      @(posedge aclk); #1;
      cyc++;
    end
    s_if.valid = 1'b0;
    if (pend) junk = exp_q.pop_back();
  endtask

  task automatic retire_one(input logic [63:0] cnt_before);
    m_if.rsp_done = 1'b1;
    m_if.rsp_data = $urandom;
    @(negedge aclk);
    chk("cnt_before_done", outstanding, cnt_before);
    @(posedge aclk); #1;
    m_if.rsp_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL tb_timeout observed=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    aresetn = 1'b0; drain_req = 1'b0; lim_drain_req = 1'b0;
    s_if.valid = 1'b0;  s_if.req = '0;  m_if.ready = 1'b0;  m_if.rsp_done = 1'b0;  m_if.rsp_data = '0;
    ls_if.valid = 1'b0; ls_if.req = '0; lm_if.ready = 1'b0; lm_if.rsp_done = 1'b0; lm_if.rsp_data = '0;
    @(negedge aclk);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_ack", drain_ack, 0);
    chk("rst_err", drain_err, 0);
    chk("rst_m_valid", m_if.valid, 0);
    @(posedge aclk); #1;
    aresetn = 1'b1;

    // Back-to-back flow
    m_if.ready = 1'b1;
    offer(5, acc);
    chk("b2b_accepted", acc, 5);
    @(negedge aclk);
    chk("b2b_outstanding", outstanding, 5);
    chk("b2b_sb_empty", exp_q.size(), 0);
    @(posedge aclk); #1;
    for (int i = 0; i < 5; i++) retire_one(5 - i);
    @(negedge aclk);
    chk("b2b_drained", outstanding, 0);

    // Full limit on the 4-deep instance
    @(posedge aclk); #1;
    ls_if.valid = 1'b1; ls_if.req = 32'hABCD; lm_if.ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      chk("lim_ready", ls_if.ready, (i < 4));
      chk("lim_cnt", lim_out, (i < 4) ? i : 4);
      @(posedge aclk); #1;
    end
    lm_if.rsp_done = 1'b1;
    @(negedge aclk);
    chk("lim_full_ready", ls_if.ready, 0);
    @(posedge aclk); #1;
    lm_if.rsp_done = 1'b0;
    @(negedge aclk);
    chk("lim_after_done_cnt", lim_out, 3);
    chk("lim_after_done_ready", ls_if.ready, 1);
    chk("lim_after_done_valid", lm_if.valid, 1);
    @(posedge aclk); #1;
    ls_if.valid = 1'b0;
    @(negedge aclk);
    chk("lim_refill_cnt", lim_out, 4);

    // Simultaneous events
    @(posedge aclk); #1;
    m_if.rsp_done = 1'b1;
    @(posedge aclk); #1;
    m_if.rsp_done = 1'b0;
    @(negedge aclk);
    chk("done_at_zero", outstanding, 0);
    @(posedge aclk); #1;
    offer(1, acc);
    exp_q.push_back(next_id);
    s_if.req = next_id; s_if.valid = 1'b1; m_if.rsp_done = 1'b1; next_id++;
    @(negedge aclk);
    chk("simul_ready", s_if.ready, 1);
    @(posedge aclk); #1;
    s_if.valid = 1'b0; m_if.rsp_done = 1'b0;
    @(negedge aclk);
    chk("simul_hold", outstanding, 1);
    @(posedge aclk); #1;
    retire_one(1);

    // Drain with traffic in flight; third request races drain_req
    offer(2, acc);
    exp_q.push_back(next_id);
    s_if.req = next_id; s_if.valid = 1'b1; drain_req = 1'b1; next_id++;
    @(negedge aclk);
    chk("drain_edge_ready", s_if.ready, 1);
    @(posedge aclk); #1;
    exp_q.push_back(next_id);
    s_if.req = next_id; next_id++;
    @(negedge aclk);
    chk("drain_blocked_valid", m_if.valid, 0);
    chk("drain_blocked_ready", s_if.ready, 0);
    chk("drain_cnt", outstanding, 3);
    @(posedge aclk); #1;
    for (int i = 0; i < 3; i++) retire_one(3 - i);
    @(negedge aclk);
    chk("drain_ack_not_yet", drain_ack, 0);
    chk("drain_zero", outstanding, 0);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("drain_ack_rise", drain_ack, 1);
    chk("quiesced_valid", m_if.valid, 0);
    @(posedge aclk); #1;
    drain_req = 1'b0;
    @(negedge aclk);
    chk("release_ack_held", drain_ack, 1);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("release_ack_fall", drain_ack, 0);
    chk("release_flow", m_if.valid, 1);
    @(posedge aclk); #1;
    s_if.valid = 1'b0;
    next_id++;
    @(negedge aclk);
    chk("release_cnt", outstanding, 1);
    chk("release_sb_empty", exp_q.size(), 0);
    @(posedge aclk); #1;
    retire_one(1);

    // Drain abort
    offer(2, acc);
    drain_req = 1'b1;
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("abort_blocked", s_if.ready, 0);
    @(posedge aclk); #1;
    drain_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      chk("abort_no_ack", drain_ack, 0);
      @(posedge aclk); #1;
    end
    @(negedge aclk);
    chk("abort_active", s_if.ready, 1);
    chk("abort_cnt", outstanding, 2);
    @(posedge aclk); #1;
    retire_one(2);
    retire_one(1);

    // Stuck drain: watchdog when enabled, otherwise err must stay low; then reset mid-drain
    offer(1, acc);
    drain_req = 1'b1;
    repeat (100) @(posedge aclk);
    @(negedge aclk);
    chk("wd_before", drain_err, 0);
    @(posedge aclk);
    @(negedge aclk);
`ifdef DMA_QUIESCE_TIMEOUT_EN
    chk("wd_fired", drain_err, 1);
`else
    chk("wd_absent", drain_err, 0);
`endif
    chk("wd_no_ack", drain_ack, 0);
    chk("wd_cnt", outstanding, 1);
    #1;
    aresetn = 1'b0;
    #1;
    chk("mid_rst_cnt", outstanding, 0);
    chk("mid_rst_ack", drain_ack, 0);
    chk("mid_rst_err", drain_err, 0);
    drain_req = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    chk("post_rst_ready", s_if.ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
